// File: rtl/codec_i2c_pkg.sv
// rtl/codec_i2c_pkg.sv - shared encodings and helpers for the codec I2C master
//
// Purpose: command encodings, FSM state encoding and the per-slot SDA drive
// rule shared by codec_i2c_master and its bench.
// Ports: none (package).
package codec_i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_STOP  = 2'd2,
    ST_XFER  = 2'd3
  } state_t;

  // First slot of a byte transfer; slots count down to the ACK slot 0.
  localparam logic [3:0] FIRST_SLOT = 4'd8;

  // SDA output-enable for phase 0 of a transfer slot.
  // Data slots 8..1 carry bit slot-1 (MSB first); slot 0 is the ACK slot.
  // The receiving side always releases SDA so the other end can drive it.
  function automatic logic slot_sda_oe(input logic       is_read,
                                       input logic [3:0] slot,
                                       input logic [7:0] wbyte,
                                       input logic       ack);
    if (slot == 4'd0) begin
      return is_read ? ~ack : 1'b0;
    end
    return is_read ? 1'b0 : ~wbyte[3'(slot - 4'd1)];
  endfunction

endpackage

// File: rtl/codec_i2c_tick.sv
// rtl/codec_i2c_tick.sv - quarter-bit divider for the codec I2C master
//
// Purpose: produces a one-cycle tick every DIV clocks. The count runs
// DIV-1 down to 0; reload restarts it so a new command begins at a phase
// boundary, and hold freezes it (clock stretching).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   reload    - restart the count at DIV-1
//   hold      - freeze the count and suppress tick
//   tick      - one-cycle pulse when the count expires
module codec_i2c_tick #(
  parameter int DIV = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0) && !hold;

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      cnt <= TOP;
    end else if (!hold) begin
      cnt <= (cnt == '0) ? TOP : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/codec_i2c_master.sv
// rtl/codec_i2c_master.sv - byte-level open-drain I2C master for the audio codec
//
// Purpose: executes START / STOP / WRITE byte / READ byte commands as SCL/SDA
// waveforms, four phases per bit, and reports the slave ACK or read byte.
// Optional feature macro: CODEC_I2C_MASTER_STRETCH_EN (slave clock stretching
// via a 2-flop synchronised scl_i); when undefined scl_i is ignored.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cmd, cmd_data,      - command (START/STOP/WRITE/READ), write byte,
//   cmd_ack             - ACK bit driven after a READ (0 = ACK)
//   cmd_valid/cmd_ready - command handshake; ready means idle
//   rsp_data            - last byte read, held until the next READ completes
//   rsp_nak             - last WRITE's slave ACK bit (1 = NAK)
//   rsp_valid           - one-cycle pulse on command completion
//   scl_oe, sda_oe      - pull the line low when 1 (registered)
//   scl_i, sda_i        - pad inputs
module codec_i2c_master
  import codec_i2c_pkg::*;
#(
  parameter int DIV = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_nak,
  output logic       rsp_valid,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [3:0] slot, slot_n;

  logic       tick, hold, accept, enter, done;
  logic       is_read, is_read_sel;
  logic       ack_q, ack_sel;
  logic [7:0] wbyte_q, wbyte_sel;
  logic [8:0] shreg;
  logic       scl_d, sda_d;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Completion is the tick that ends phase 3 of the final phase group.
  assign done = (state != ST_IDLE) && tick && (phase == 2'd3) &&
                ((state != ST_XFER) || (slot == 4'd0));

  // A phase is entered on accept or on any tick that does not return to IDLE.
  assign enter = accept || ((state != ST_IDLE) && tick && (state_n != ST_IDLE));

`ifdef CODEC_I2C_MASTER_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
    end
  end

  // SCL released by us but still seen low: the slave is stretching.
  assign hold = (state != ST_IDLE) && (phase != 2'd0) && !scl_oe && !scl_sync[1];
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold         = 1'b0;
`endif

  codec_i2c_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .reload (accept),
    .hold   (hold),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= 2'd0;
      slot  <= 4'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      slot  <= slot_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    phase_n = phase;
    slot_n  = slot;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          phase_n = 2'd0;
          slot_n  = FIRST_SLOT;
          case (cmd)
            CMD_START: state_n = ST_START;
            CMD_STOP:  state_n = ST_STOP;
            default:   state_n = ST_XFER;
          endcase
        end
      end
      default: begin
        if (tick) begin
          phase_n = phase + 2'd1;
          if (phase == 2'd3) begin
            if ((state == ST_XFER) && (slot != 4'd0)) begin
              slot_n = slot - 4'd1;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  // Output logic: next values of the line enables. Each phase touches at
  // most one line, so SCL and SDA never change in the same cycle; lines not
  // named by the entered phase keep their previous level.
  always_comb begin
    // On the accept cycle the command fields are not yet latched.
    is_read_sel = (state == ST_IDLE) ? (cmd == CMD_READ) : is_read;
    wbyte_sel   = (state == ST_IDLE) ? cmd_data : wbyte_q;
    ack_sel     = (state == ST_IDLE) ? cmd_ack : ack_q;
    scl_d       = scl_oe;
    sda_d       = sda_oe;
    if (enter) begin
      case (state_n)
        ST_START: begin
          case (phase_n)
            2'd0:    sda_d = 1'b0;
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b1;
            default: scl_d = 1'b1;
          endcase
        end
        ST_STOP: begin
          case (phase_n)
            2'd0:    sda_d = 1'b1;
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b0;
            default: ;
          endcase
        end
        ST_XFER: begin
          case (phase_n)
            2'd0:    sda_d = slot_sda_oe(is_read_sel, slot_n, wbyte_sel, ack_sel);
            2'd1:    scl_d = 1'b0;
            2'd3:    scl_d = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_nak   <= 1'b0;
      is_read   <= 1'b0;
      ack_q     <= 1'b0;
      wbyte_q   <= 8'h00;
      shreg     <= 9'h000;
    end else begin
      scl_oe    <= scl_d;
      sda_oe    <= sda_d;
      rsp_valid <= done;
      if (accept) begin
        is_read <= (cmd == CMD_READ);
        ack_q   <= cmd_ack;
        wbyte_q <= cmd_data;
      end
      // All nine slots are sampled at the end of SCL-high; the top eight are
      // the data byte and bit 0 is the ACK slot.
      if ((state == ST_XFER) && tick && (phase == 2'd2)) begin
        shreg <= {shreg[7:0], sda_i};
      end
      if (done && (state == ST_XFER)) begin
        if (is_read) begin
          rsp_data <= shreg[8:1];
        end else begin
          rsp_nak <= shreg[0];
        end
      end
    end
  end

endmodule
